// File: rtl/pixel_in_pkg.sv
// Shared types and constants for the pixel input front end.
package pixel_in_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_WAIT_JUMP = 2'd2,
        ST_WAIT_ROW  = 2'd3
    } fsm_state_t;

    localparam int ERR_W       = 4;
    localparam int ERR_SHORT   = 0;
    localparam int ERR_LONG    = 1;
    localparam int ERR_RESTART = 2;
    localparam int ERR_ORPHAN  = 3;

    localparam int DEF_DATA_W      = 24;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_IMG_W       = 640;
    localparam int DEF_IMG_H       = 480;

endpackage

// File: rtl/sync_delay_line.sv
// WIDTH x DEPTH register shift line with async active-low reset; DEPTH=0 is a wire.
module sync_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = clk ^ rst_n;
            assign dout      = din;
        end else begin : g_line
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pixel_input_frontend.sv
// Pixel input stage: delay line, frame-tracking FSM with x/y annotation, sticky error flags.
// state        | meaning
// ST_IDLE      | no frame in progress, waiting for Start with a valid pixel
// ST_ACTIVE    | inside a row, fewer than IMG_W pixels accepted
// ST_WAIT_JUMP | row full, waiting for the end-of-row pulse
// ST_WAIT_ROW  | between rows, waiting for the first pixel of the next row
module pixel_input_frontend
    import pixel_in_pkg::*;
#(
    parameter  int DATA_W      = DEF_DATA_W,
    parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter  int IMG_W       = DEF_IMG_W,
    parameter  int IMG_H       = DEF_IMG_H,
    localparam int XW          = $clog2(IMG_W),
    localparam int YW          = $clog2(IMG_H)
) (
    input  logic              Clk_in,
    input  logic              Rst_n_in,
    input  logic              Start_in,
    input  logic              H_Valid_in,
    input  logic              H_Jump_in,
    input  logic [DATA_W-1:0] Bmp_Data,
    input  logic              Err_Clr_in,
    output logic              pixel_ready,
    output logic              pixel_valid,
    output logic              line_end,
    output logic              frame_end,
    output logic [DATA_W-1:0] pixel_data,
    output logic [XW-1:0]     pixel_x,
    output logic [YW-1:0]     pixel_y,
    output logic              busy,
    output logic [ERR_W-1:0]  err_status
);

    localparam int              CW       = $clog2(IMG_W + 1);
    localparam int              BW       = DATA_W + 3;
    localparam logic [CW-1:0]   COL_FULL = CW'(IMG_W);
    localparam logic [YW-1:0]   ROW_LAST = YW'(IMG_H - 1);

    logic [BW-1:0]     bus_in, bus_dly;
    logic              s_start, s_valid, s_jump;
    logic [DATA_W-1:0] s_data;

    assign bus_in = {Start_in, H_Valid_in, H_Jump_in, Bmp_Data};

    // One stage fewer than the latency: the output registers supply the last one.
    sync_delay_line #(.WIDTH(BW), .DEPTH(SYNC_STAGES - 1)) u_dly (
        .clk   (Clk_in),
        .rst_n (Rst_n_in),
        .din   (bus_in),
        .dout  (bus_dly)
    );

    assign {s_start, s_valid, s_jump, s_data} = bus_dly;

    fsm_state_t        state, state_n;
    logic [CW-1:0]     col, col_n;
    logic [YW-1:0]     row, row_n;
    logic              busy_n, row_end;
    logic              ev_ready, ev_pixel, ev_line, ev_frame;
    logic [XW-1:0]     ev_x, x_n;
    logic [YW-1:0]     ev_y, y_n;
    logic [ERR_W-1:0]  err_set, err_n;
    logic [DATA_W-1:0] data_n;

    always_ff @(posedge Clk_in or negedge Rst_n_in) begin
        if (!Rst_n_in) begin
            state       <= ST_IDLE;
            col         <= '0;
            row         <= '0;
            busy        <= 1'b0;
            pixel_ready <= 1'b0;
            pixel_valid <= 1'b0;
            line_end    <= 1'b0;
            frame_end   <= 1'b0;
            pixel_data  <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            err_status  <= '0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            row         <= row_n;
            busy        <= busy_n;
            pixel_ready <= ev_ready;
            pixel_valid <= ev_pixel;
            line_end    <= ev_line;
            frame_end   <= ev_frame;
            pixel_data  <= data_n;
            pixel_x     <= x_n;
            pixel_y     <= y_n;
            err_status  <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        col_n    = col;
        row_n    = row;
        busy_n   = busy;
        row_end  = 1'b0;
        ev_ready = 1'b0;
        ev_pixel = 1'b0;
        ev_line  = 1'b0;
        ev_frame = 1'b0;
        ev_x     = '0;
        ev_y     = '0;
        err_set  = '0;

        if (s_start && s_valid) begin
            if (state != ST_IDLE) err_set[ERR_RESTART] = 1'b1;
            ev_ready = 1'b1;
            ev_pixel = 1'b1;
            col_n    = CW'(1);
            row_n    = '0;
            busy_n   = 1'b1;
            state_n  = (col_n == COL_FULL) ? ST_WAIT_JUMP : ST_ACTIVE;
        end else if (s_start && state != ST_IDLE) begin
            err_set[ERR_RESTART] = 1'b1;
            col_n   = '0;
            row_n   = '0;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:
                    if (s_valid) err_set[ERR_ORPHAN] = 1'b1;
                ST_ACTIVE, ST_WAIT_ROW:
                    if (s_valid) begin
                        ev_pixel = 1'b1;
                        ev_x     = col[XW-1:0];
                        ev_y     = row;
                        col_n    = col + CW'(1);
                        state_n  = (col_n == COL_FULL) ? ST_WAIT_JUMP : ST_ACTIVE;
                    end
                ST_WAIT_JUMP:
                    if (s_valid) err_set[ERR_LONG] = 1'b1;
                default: ;
            endcase
        end

        // A jump sharing a cycle with a pixel is handled as if it followed that pixel.
        row_end = s_jump && (state_n != ST_IDLE);
        if (row_end) begin
            if (col_n != COL_FULL) err_set[ERR_SHORT] = 1'b1;
            ev_line = 1'b1;
            col_n   = '0;
            if (row_n == ROW_LAST) begin
                ev_frame = 1'b1;
                row_n    = '0;
                busy_n   = 1'b0;
                state_n  = ST_IDLE;
            end else begin
                row_n   = row_n + YW'(1);
                state_n = ST_WAIT_ROW;
            end
        end
    end

    always_comb begin
        err_n  = (Err_Clr_in ? '0 : err_status) | err_set;
        data_n = ev_pixel ? s_data : pixel_data;
        x_n    = ev_pixel ? ev_x : pixel_x;
        y_n    = ev_pixel ? ev_y : pixel_y;
    end

endmodule

// File: tb/tb_pixel_input_frontend.sv
// Directed bench: three instances (latency 1, 2, 5) share stimulus; output events are logged per instance.
module tb_pixel_input_frontend;

    localparam int DW = 24;
    localparam int IW = 4;
    localparam int IH = 3;

    logic clk = 1'b0, rst_n = 1'b1;
    logic start = 1'b0, hv = 1'b0, hj = 1'b0, clr = 1'b0;
    logic [DW-1:0] din = '0;

    logic [2:0]         rdy, pv, le, fe, bsy;
    logic [2:0][DW-1:0] pd;
    logic [2:0][1:0]    px, py;
    logic [2:0][3:0]    err;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int SS = (g == 0) ? 1 : (g == 1) ? 2 : 5;
        pixel_input_frontend #(.DATA_W(DW), .SYNC_STAGES(SS), .IMG_W(IW), .IMG_H(IH)) u_dut (
            .Clk_in      (clk),
            .Rst_n_in    (rst_n),
            .Start_in    (start),
            .H_Valid_in  (hv),
            .H_Jump_in   (hj),
            .Bmp_Data    (din),
            .Err_Clr_in  (clr),
            .pixel_ready (rdy[g]),
            .pixel_valid (pv[g]),
            .line_end    (le[g]),
            .frame_end   (fe[g]),
            .pixel_data  (pd[g]),
            .pixel_x     (px[g]),
            .pixel_y     (py[g]),
            .busy        (bsy[g]),
            .err_status  (err[g])
        );
    end

    typedef struct {
        int          t;
        logic        r, v, l, f;
        logic [DW-1:0] d;
        logic [1:0]  x, y;
    } ev_t;

    ev_t evq[3][$];
    int  cnt = 0;
    int  checks = 0, failures = 0;
    int  last_t = 0;
    int  tin[16];
    int  base[3];
    int  lat[3] = '{1, 2, 5};

    always @(posedge clk) cnt <= cnt + 1;

    always @(negedge clk)
        for (int i = 0; i < 3; i++)
            if (rdy[i] | pv[i] | le[i] | fe[i])
                evq[i].push_back('{cnt, rdy[i], pv[i], le[i], fe[i], pd[i], px[i], py[i]});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic v, input logic j, input logic [DW-1:0] d, input logic c);
        @(negedge clk);
        start = s; hv = v; hj = j; din = d; clr = c;
        last_t = cnt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic mark;
        for (int i = 0; i < 3; i++) base[i] = evq[i].size();
    endtask

    task automatic drive_frame(input int l0, input int l1, input int l2);
        int n = 0;
        int lens[3];
        lens = '{l0, l1, l2};
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < lens[r]; c++) begin
                cyc((r == 0 && c == 0), 1'b1, 1'b0, DW'(n + 1), 1'b0);
                tin[n] = last_t;
                n++;
            end
            cyc(1'b0, 1'b0, 1'b1, '0, 1'b0);
        end
        idle(8);
    endtask

    task automatic count_ev(input int di, output int nv, output int nr, output int nl, output int nf, output int nfl);
        nv = 0; nr = 0; nl = 0; nf = 0; nfl = 0;
        for (int k = base[di]; k < evq[di].size(); k++) begin
            nv += int'(evq[di][k].v);
            nr += int'(evq[di][k].r);
            nl += int'(evq[di][k].l);
            nf += int'(evq[di][k].f);
            nfl += int'(evq[di][k].f & evq[di][k].l);
        end
    endtask

    task automatic nth_pix(input int di, input int n, output ev_t e);
        int seen = 0;
        e = '{t: -1, r: 1'b0, v: 1'b0, l: 1'b0, f: 1'b0, d: '0, x: '0, y: '0};
        for (int k = base[di]; k < evq[di].size(); k++) begin
            if (evq[di][k].v) begin
                if (seen == n) begin
                    e = evq[di][k];
                    break;
                end
                seen++;
            end
        end
    endtask

    initial begin
        int nv, nr, nl, nf, nfl;
        ev_t e;
        int sx[11] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 2, 3};
        int sy[11] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 2};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {rdy, pv, le, fe, bsy, err, pd, px, py}, '0);
        rst_n = 1'b1;
        idle(2);

        // clean frame on all three latencies
        mark();
        drive_frame(4, 4, 4);
        for (int di = 0; di < 3; di++) begin
            count_ev(di, nv, nr, nl, nf, nfl);
            chk($sformatf("clean_counts_ss%0d", lat[di]), {8'(nv), 8'(nr), 8'(nl), 8'(nf), 8'(nfl)},
                {8'd12, 8'd1, 8'd3, 8'd1, 8'd1});
            for (int k = 0; k < 12; k++) begin
                nth_pix(di, k, e);
                chk($sformatf("clean_pix%0d_ss%0d", k, lat[di]), {8'(e.t - tin[k]), e.r, e.d, e.x, e.y},
                    {8'(lat[di]), (k == 0), DW'(k + 1), 2'(k % IW), 2'(k / IW)});
            end
            chk($sformatf("clean_err_busy_ss%0d", lat[di]), {err[di], bsy[di]}, 5'b0000_0);
        end

        // short row 1
        mark();
        drive_frame(4, 3, 4);
        count_ev(1, nv, nr, nl, nf, nfl);
        chk("short_counts", {8'(nv), 8'(nr), 8'(nl), 8'(nfl)}, {8'd11, 8'd1, 8'd3, 8'd1});
        for (int k = 0; k < 11; k++) begin
            nth_pix(1, k, e);
            chk($sformatf("short_pix%0d", k), {8'(e.t - tin[k]), e.d, e.x, e.y},
                {8'd2, DW'(k + 1), 2'(sx[k]), 2'(sy[k])});
        end
        chk("short_err", err[1], 4'b0001);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        idle(1);
        chk("short_err_clr", err, '0);

        // long row 0
        mark();
        drive_frame(5, 4, 4);
        count_ev(1, nv, nr, nl, nf, nfl);
        chk("long_counts", {8'(nv), 8'(nl), 8'(nfl)}, {8'd12, 8'd3, 8'd1});
        for (int k = 0; k < 12; k++) begin
            nth_pix(1, k, e);
            chk($sformatf("long_pix%0d", k), {e.d, e.x, e.y},
                {DW'(k < 4 ? k + 1 : k + 2), 2'(k % IW), 2'(k / IW)});
        end
        chk("long_err", err[1], 4'b0010);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        idle(1);

        // orphan pixel, then restart mid-row 1
        mark();
        cyc(1'b0, 1'b1, 1'b0, DW'('h55), 1'b0);
        idle(6);
        count_ev(1, nv, nr, nl, nf, nfl);
        chk("orphan_nopix", 8'(nv), 8'd0);
        chk("orphan_err", err[1], 4'b1000);
        mark();
        for (int k = 1; k <= 4; k++) cyc((k == 1), 1'b1, 1'b0, DW'(k), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, '0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, DW'(5), 1'b0);
        cyc(1'b0, 1'b1, 1'b0, DW'(6), 1'b0);
        cyc(1'b1, 1'b1, 1'b0, DW'('h77), 1'b0);
        for (int k = 'h78; k <= 'h7A; k++) cyc(1'b0, 1'b1, 1'b0, DW'(k), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, '0, 1'b0);
        idle(6);
        count_ev(1, nv, nr, nl, nf, nfl);
        chk("restart_counts", {8'(nv), 8'(nr), 8'(nl), 8'(nf)}, {8'd10, 8'd2, 8'd2, 8'd0});
        nth_pix(1, 5, e);
        chk("restart_pre", {e.r, e.d, e.x, e.y}, {1'b0, DW'(6), 2'd1, 2'd1});
        nth_pix(1, 6, e);
        chk("restart_pix", {e.r, e.d, e.x, e.y}, {1'b1, DW'('h77), 2'd0, 2'd0});
        nth_pix(1, 9, e);
        chk("restart_last", {e.r, e.d, e.x, e.y}, {1'b0, DW'('h7A), 2'd3, 2'd0});
        chk("restart_err_busy", {err[1], bsy[1]}, {4'b1100, 1'b1});
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        idle(1);
        chk("restart_err_clr", err[1], 4'b0000);

        // asynchronous reset in the middle of row 1
        cyc(1'b0, 1'b1, 1'b0, DW'('h81), 1'b0);
        cyc(1'b0, 1'b1, 1'b0, DW'('h82), 1'b0);
        @(posedge clk);
        #1;
        chk("prereset_out", {pv[1], bsy[1], pd[1], px[1], py[1]}, {1'b1, 1'b1, DW'('h81), 2'd0, 2'd1});
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_out", {rdy, pv, le, fe, bsy, err, pd, px, py}, '0);
        @(negedge clk);
        hv = 1'b0; din = '0;
        rst_n = 1'b1;
        idle(2);
        mark();
        drive_frame(4, 4, 4);
        count_ev(1, nv, nr, nl, nf, nfl);
        chk("after_reset_counts", {8'(nv), 8'(nr), 8'(nfl)}, {8'd12, 8'd1, 8'd1});
        nth_pix(1, 0, e);
        chk("after_reset_first", {8'(e.t - tin[0]), e.r, e.d, e.x, e.y}, {8'd2, 1'b1, DW'(1), 2'd0, 2'd0});
        nth_pix(1, 11, e);
        chk("after_reset_last", {e.d, e.x, e.y}, {DW'(12), 2'd3, 2'd2});
        chk("after_reset_err", {err[1], bsy[1]}, 5'b0000_0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
